// File: rtl/spi_pkg.sv
// spi_pkg: shared SPI mode encodings, mode-field bit positions and FSM state type.
package spi_pkg;
  localparam logic [1:0] SPI_MODE0 = 2'b00;
  localparam logic [1:0] SPI_MODE1 = 2'b01;
  localparam logic [1:0] SPI_MODE2 = 2'b10;
  localparam logic [1:0] SPI_MODE3 = 2'b11;
  localparam int CPOL_BIT = 1;
  localparam int CPHA_BIT = 0;
  typedef enum logic {IDLE, ACTIVE} state_t;
endpackage

// File: rtl/spi_sync_edge.sv
// spi_sync_edge: N-stage synchroniser for an asynchronous pin with rise/fall detection.
module spi_sync_edge #(
  parameter int STAGES = 2,
  parameter bit INIT   = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_async,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);
  logic [STAGES-1:0] r_sync;
  logic              r_dly;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sync <= {STAGES{INIT}};
      r_dly  <= INIT;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_async};
      r_dly  <= r_sync[STAGES-1];
    end
  end
  assign o_level = r_sync[STAGES-1];
  assign o_rise  = o_level & ~r_dly;
  assign o_fall  = ~o_level & r_dly;
endmodule

// File: rtl/spi_peri_core.sv
// spi_peri_core: oversampled full-duplex SPI peripheral, all four CPOL/CPHA modes,
// configurable word width and bit order, ready/valid buffering on both sides.
module spi_peri_core
  import spi_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter bit MSB_FIRST   = 1'b1,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sclk,
  input  logic              cs_n,
  input  logic              mosi,
  output logic              miso,
  output logic              miso_oe,
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic              rx_overrun,
  output logic              tx_underrun,
  output logic              frame_abort
);
  localparam int CW = $clog2(DATA_W);
  state_t r_state, w_next;
  logic w_sclk_lvl_unused, w_sclk_rise, w_sclk_fall;
  logic w_cs_lvl, w_cs_rise, w_cs_fall;
  logic [SYNC_STAGES-1:0] r_mosi_sync, r_settle;
  logic r_arm, r_cpol, r_cpha, r_pend, r_done;
  logic [CW-1:0] r_cnt;
  logic [DATA_W-1:0] r_rx, r_tx, w_rx_next, w_tx_next, r_rx_data;
  logic r_rx_valid, r_rx_overrun, r_tx_ready, r_tx_underrun, r_frame_abort;
  logic w_start, w_stop, w_active, w_lead, w_trail, w_sample, w_shift, w_last, w_load, w_mosi;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .INIT(1'b0)) u_sclk_sync (
    .clk(clk), .rst_n(rst_n), .i_async(sclk),
    .o_level(w_sclk_lvl_unused), .o_rise(w_sclk_rise), .o_fall(w_sclk_fall)
  );
  spi_sync_edge #(.STAGES(SYNC_STAGES), .INIT(1'b1)) u_cs_sync (
    .clk(clk), .rst_n(rst_n), .i_async(cs_n),
    .o_level(w_cs_lvl), .o_rise(w_cs_rise), .o_fall(w_cs_fall)
  );

  // A frame may only start once cs_n has been seen high after reset, so a
  // select held low across reset cannot open a frame mid-transfer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_mosi_sync <= '0;
      r_settle    <= '0;
      r_arm       <= 1'b0;
    end else begin
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi};
      r_settle    <= {r_settle[SYNC_STAGES-2:0], 1'b1};
      r_arm       <= r_arm | (r_settle[SYNC_STAGES-1] & w_cs_lvl);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else r_state <= w_next;
  end

  always_comb begin
    w_start = (r_state == IDLE) & w_cs_fall & r_arm;
    w_stop  = (r_state == ACTIVE) & w_cs_rise;
    w_next  = w_start ? ACTIVE : w_stop ? IDLE : r_state;
  end

  assign w_mosi    = r_mosi_sync[SYNC_STAGES-1];
  assign w_active  = (r_state == ACTIVE) & ~w_cs_rise;
  assign w_lead    = r_cpol ? w_sclk_fall : w_sclk_rise;
  assign w_trail   = r_cpol ? w_sclk_rise : w_sclk_fall;
  assign w_sample  = w_active & (r_cpha ? w_trail : w_lead);
  assign w_shift   = w_active & (r_cpha ? w_lead : w_trail);
  assign w_last    = r_cnt == CW'(DATA_W - 1);
  assign w_load    = w_start | (w_shift & r_pend);
  assign w_rx_next = MSB_FIRST ? {r_rx[DATA_W-2:0], w_mosi} : {w_mosi, r_rx[DATA_W-1:1]};
  assign w_tx_next = MSB_FIRST ? {r_tx[DATA_W-2:0], 1'b0} : {1'b0, r_tx[DATA_W-1:1]};

  // With cpha=1 the first leading edge of a frame only presents the bit
  // already loaded at cs_n fall; later words reload on that edge via r_pend.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cpol        <= 1'b0;
      r_cpha        <= 1'b0;
      r_cnt         <= '0;
      r_pend        <= 1'b0;
      r_done        <= 1'b0;
      r_rx          <= '0;
      r_tx          <= '0;
      r_rx_data     <= '0;
      r_rx_valid    <= 1'b0;
      r_rx_overrun  <= 1'b0;
      r_tx_ready    <= 1'b0;
      r_tx_underrun <= 1'b0;
      r_frame_abort <= 1'b0;
    end else begin
      r_tx_ready    <= w_load & tx_valid;
      r_tx_underrun <= w_load & ~tx_valid;
      r_frame_abort <= w_stop & (r_cnt != '0);
      r_done        <= w_sample & w_last;
      r_rx_overrun  <= r_done & r_rx_valid & ~rx_ready;
      if (w_start) begin
        r_cpol <= mode[CPOL_BIT];
        r_cpha <= mode[CPHA_BIT];
      end
      if (w_load) r_tx <= tx_valid ? tx_data : '0;
      else if (w_shift && !(r_cpha && r_cnt == '0)) r_tx <= w_tx_next;
      if (w_sample) r_rx <= w_rx_next;
      r_cnt  <= (w_start | w_stop | (w_sample & w_last)) ? '0 : w_sample ? r_cnt + 1'b1 : r_cnt;
      r_pend <= (w_load | w_stop) ? 1'b0 : (w_sample & w_last) ? 1'b1 : r_pend;
      if (r_done && !(r_rx_valid && !rx_ready)) begin
        r_rx_data  <= r_rx;
        r_rx_valid <= 1'b1;
      end else if (r_rx_valid && rx_ready) r_rx_valid <= 1'b0;
    end
  end

  assign miso        = (r_state == ACTIVE) & (MSB_FIRST ? r_tx[DATA_W-1] : r_tx[0]);
  assign miso_oe     = r_state == ACTIVE;
  assign tx_ready    = r_tx_ready;
  assign tx_underrun = r_tx_underrun;
  assign rx_data     = r_rx_data;
  assign rx_valid    = r_rx_valid;
  assign rx_overrun  = r_rx_overrun;
  assign frame_abort = r_frame_abort;
endmodule

// File: tb/tb_spi_peri_core.sv
// tb_spi_peri_core: randomized SPI controller model driving an 8-bit MSB-first and a
// 16-bit LSB-first peripheral on a shared bus, checked against bench-side expectations.
module tb_spi_peri_core;
  localparam int S = 2;
  logic clk = 1'b0, rst_n = 1'b0, sclk = 1'b0, mosi = 1'b0;
  logic [1:0] mode = 2'b00;
  logic [1:0] cs_n = 2'b11, tx_valid = 2'b11, rx_ready = 2'b00;
  logic [1:0] miso, miso_oe, tx_ready, rx_valid, rx_overrun, tx_underrun, frame_abort;
  logic [7:0] tx_data8 = '0, rx_data8;
  logic [15:0] tx_data16 = '0, rx_data16;
  int n_chk = 0, n_pass = 0, cyc = 0, last_samp = 0;
  int n_rxv[2] = '{0, 0};
  int n_ovr[2] = '{0, 0};
  int n_txr[2] = '{0, 0};
  int n_txu[2] = '{0, 0};
  int n_ab[2] = '{0, 0};
  int rise_cyc[2] = '{0, 0};
  logic [31:0] rx_log[2][4];
  logic [1:0] pv = 2'b00;

  always #5 clk = ~clk;

  spi_peri_core #(.DATA_W(8), .MSB_FIRST(1'b1), .SYNC_STAGES(S)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .sclk(sclk), .cs_n(cs_n[0]), .mosi(mosi), .miso(miso[0]),
    .miso_oe(miso_oe[0]), .mode(mode), .tx_data(tx_data8), .tx_valid(tx_valid[0]),
    .tx_ready(tx_ready[0]), .rx_data(rx_data8), .rx_valid(rx_valid[0]), .rx_ready(rx_ready[0]),
    .rx_overrun(rx_overrun[0]), .tx_underrun(tx_underrun[0]), .frame_abort(frame_abort[0])
  );
  spi_peri_core #(.DATA_W(16), .MSB_FIRST(1'b0), .SYNC_STAGES(S)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .sclk(sclk), .cs_n(cs_n[1]), .mosi(mosi), .miso(miso[1]),
    .miso_oe(miso_oe[1]), .mode(mode), .tx_data(tx_data16), .tx_valid(tx_valid[1]),
    .tx_ready(tx_ready[1]), .rx_data(rx_data16), .rx_valid(rx_valid[1]), .rx_ready(rx_ready[1]),
    .rx_overrun(rx_overrun[1]), .tx_underrun(tx_underrun[1]), .frame_abort(frame_abort[1])
  );

  always @(posedge clk) begin
    cyc++;
    #1;
    for (int i = 0; i < 2; i++) begin
      if (rx_valid[i] && !pv[i]) begin
        rise_cyc[i] = cyc;
        rx_log[i][n_rxv[i] % 4] = (i == 0) ? 32'(rx_data8) : 32'(rx_data16);
        n_rxv[i]++;
      end
      if (rx_overrun[i]) n_ovr[i]++;
      if (tx_ready[i]) n_txr[i]++;
      if (tx_underrun[i]) n_txu[i]++;
      if (frame_abort[i]) n_ab[i]++;
    end
    pv = rx_valid;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic half();
    repeat (6) @(posedge clk);
    #2;
  endtask

  task automatic cs_low(input int d, input logic [1:0] md);
    @(posedge clk);
    #2;
    mode = md;
    sclk = md[1];
    half();
    cs_n[d] = 1'b0;
    half();
  endtask

  task automatic cs_high(input int d);
    half();
    cs_n[d] = 1'b1;
    half();
    half();
  endtask

  // Plain SPI controller: drives mosi in the chosen bit order, captures miso.
  task automatic spi_word(input int d, input logic [1:0] md, input logic [31:0] w, input int n,
                          input bit lsb, input bit flip, output logic [31:0] cap);
    int pos;
    cap = '0;
    for (int k = 0; k < n; k++) begin
      pos = lsb ? k : n - 1 - k;
      if (!md[0]) begin
        mosi = w[pos];
        half();
        cap[pos] = miso[d];
        sclk = ~md[1];
        if (k == n - 1) last_samp = cyc;
        half();
        sclk = md[1];
      end else begin
        sclk = ~md[1];
        mosi = w[pos];
        half();
        cap[pos] = miso[d];
        sclk = md[1];
        if (k == n - 1) last_samp = cyc;
        half();
      end
      if (flip && k == n / 2) mode = ~mode;
    end
  endtask

  task automatic ack(input int d);
    @(posedge clk);
    #2;
    rx_ready[d] = 1'b1;
    @(posedge clk);
    #2;
    rx_ready[d] = 1'b0;
    @(posedge clk);
    #1;
    chk("rx_clear", 32'(rx_valid[d]), 0);
  endtask

  task automatic frame8(input logic [1:0] md, input logic [31:0] w, input logic [31:0] tx, input bit flip);
    int b_txr, b_rxv, b_ovr, b_ab;
    logic [31:0] cap;
    b_txr = n_txr[0];
    b_rxv = n_rxv[0];
    b_ovr = n_ovr[0];
    b_ab = n_ab[0];
    tx_data8 = tx[7:0];
    cs_low(0, md);
    chk("tx_ready_start", n_txr[0] - b_txr, 1);
    chk("miso_oe_active", 32'(miso_oe[0]), 1);
    spi_word(0, md, w, 8, 1'b0, flip, cap);
    cs_high(0);
    chk("rx_data", 32'(rx_data8), w);
    chk("rx_valid_held", 32'(rx_valid[0]), 1);
    chk("miso_capture", cap, tx);
    chk("rx_events", n_rxv[0] - b_rxv, 1);
    chk("no_overrun", n_ovr[0] - b_ovr, 0);
    chk("no_abort", n_ab[0] - b_ab, 0);
    chk("rx_latency", rise_cyc[0] - last_samp, S + 2);
    ack(0);
  endtask

  initial begin
    int b0, b1, b2;
    logic [31:0] w, t0, t1, c0, c1;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("reset_outs", {miso_oe, miso, tx_ready, rx_valid, rx_overrun, tx_underrun, frame_abort}, 0);
    chk("reset_rx_data", {rx_data16, rx_data8}, 0);
    half();
    frame8(2'b00, 32'hA5, 32'h3C, 1'b0);
    for (int m = 1; m < 4; m++) frame8(2'(m), 32'h96, 32'h5A, 1'b1);
    for (int r = 0; r < 2; r++)
      for (int m = 0; m < 4; m++)
        frame8(2'(m), 32'($urandom_range(0, 255)), 32'($urandom_range(0, 255)), 1'(r));
    // 16-bit LSB-first, two back-to-back words in one frame
    rx_ready[1] = 1'b1;
    t0 = 32'($urandom_range(0, 65535));
    t1 = 32'($urandom_range(0, 65535));
    b0 = n_rxv[1];
    b1 = n_txr[1];
    b2 = n_ovr[1];
    tx_data16 = t0[15:0];
    cs_low(1, 2'b00);
    chk("w16_tx_ready_start", n_txr[1] - b1, 1);
    tx_data16 = t1[15:0];
    spi_word(1, 2'b00, 32'h1234, 16, 1'b1, 1'b0, c0);
    spi_word(1, 2'b00, 32'hBEEF, 16, 1'b1, 1'b0, c1);
    cs_high(1);
    chk("w16_rx_events", n_rxv[1] - b0, 2);
    chk("w16_word0", rx_log[1][b0 % 4], 32'h1234);
    chk("w16_word1", rx_log[1][(b0 + 1) % 4], 32'hBEEF);
    chk("w16_no_overrun", n_ovr[1] - b2, 0);
    chk("w16_miso0", c0, t0);
    chk("w16_miso1", c1, t1);
    chk("w16_valid_cleared", 32'(rx_valid[1]), 0);
    rx_ready[1] = 1'b0;
    // overrun: second word dropped while rx_valid held
    b0 = n_ovr[0];
    cs_low(0, 2'b00);
    spi_word(0, 2'b00, 32'h11, 8, 1'b0, 1'b0, c0);
    spi_word(0, 2'b00, 32'h22, 8, 1'b0, 1'b0, c1);
    cs_high(0);
    chk("ovr_rx_data_kept", 32'(rx_data8), 32'h11);
    chk("ovr_pulse_count", n_ovr[0] - b0, 1);
    chk("ovr_rx_valid", 32'(rx_valid[0]), 1);
    ack(0);
    // abort after 5 bits
    b0 = n_ab[0];
    b1 = n_rxv[0];
    cs_low(0, 2'b00);
    spi_word(0, 2'b00, 32'($urandom_range(0, 31)), 5, 1'b0, 1'b0, c0);
    cs_high(0);
    chk("abort_pulse", n_ab[0] - b0, 1);
    chk("abort_no_rx", n_rxv[0] - b1, 0);
    chk("abort_miso_oe", {miso_oe[0], miso[0]}, 0);
    frame8(2'b00, 32'hC3, 32'($urandom_range(0, 255)), 1'b0);
    // underrun at frame start
    tx_valid[0] = 1'b0;
    b0 = n_txu[0];
    w = 32'($urandom_range(0, 255));
    cs_low(0, 2'b01);
    chk("underrun_start", n_txu[0] - b0, 1);
    spi_word(0, 2'b01, w, 8, 1'b0, 1'b0, c0);
    cs_high(0);
    chk("underrun_miso", c0, 0);
    chk("underrun_rx", 32'(rx_data8), w);
    tx_valid[0] = 1'b1;
    ack(0);
    // reset mid-word with cs_n held low
    tx_data8 = 8'hFF;
    cs_low(0, 2'b00);
    spi_word(0, 2'b00, 32'h6E, 8, 1'b0, 1'b0, c0);
    spi_word(0, 2'b00, 32'h0F, 4, 1'b0, 1'b0, c0);
    chk("pre_reset_valid", 32'(rx_valid[0]), 1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("midreset_outs", {miso_oe, miso, tx_ready, rx_valid, rx_overrun, tx_underrun, frame_abort}, 0);
    chk("midreset_rx_data", 32'(rx_data8), 0);
    #1;
    rst_n = 1'b1;
    b0 = n_rxv[0];
    half();
    spi_word(0, 2'b00, 32'h5A, 8, 1'b0, 1'b0, c0);
    chk("no_frame_after_reset", {miso_oe[0], 1'b0}, 0);
    chk("no_rx_after_reset", n_rxv[0] - b0, 0);
    cs_high(0);
    frame8(2'b00, 32'($urandom_range(0, 255)), 32'($urandom_range(0, 255)), 1'b0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule
